// File: rtl/vlog_fsm_push_seq.sv
// Push sequencer: captures NUM_CH channel words on start, streams them in channel
// order over valid/ready, optionally appends a CRC beat, aborts on a stall timeout.

module vlog_fsm_push_seq_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (load)
            dout <= din;
    end
endmodule

module vlog_fsm_push_seq #(
    parameter int                NUM_CH      = 2,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] CRC_POLY    = 8'h07,
    parameter logic [DATA_W-1:0] CRC_INIT    = 8'h00,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     crc_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [DATA_W-1:0]        crc_out
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, PUSH, CRC} state_t;

    state_t                         state;
    logic                           crc_en_q;
    logic [DATA_W-1:0]              crc;
    logic [IDX_W-1:0]               ch_idx;
    logic [CNT_W-1:0]               stall_cnt;
    logic [NUM_CH-1:0][DATA_W-1:0]  word_q;
    logic [IDX_W-1:0]               nxt_idx;
    logic [DATA_W-1:0]              nxt_word;
    logic [DATA_W-1:0]              crc_nxt;
    logic                           cap;
    logic                           hs;
    logic                           stall;
    logic                           tmo;

    // MSB-first bitwise CRC over one word, no reflection, no final XOR.
    function automatic logic [DATA_W-1:0] crc_upd(input logic [DATA_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        logic              fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[DATA_W-1] ^ d[i];
            r  = (r << 1) ^ (fb ? CRC_POLY : '0);
        end
        return r;
    endfunction

    assign cap   = (state == IDLE) && start;
    assign hs    = out_valid && out_ready;
    assign stall = out_valid && !out_ready;
    assign tmo   = (TIMEOUT_CYC != 0) && stall && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            vlog_fsm_push_seq_lane #(.DATA_W(DATA_W)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .load (cap),
                .din  (ch_data[g*DATA_W +: DATA_W]),
                .dout (word_q[g])
            );
        end
    endgenerate

    always_comb begin
        nxt_idx  = ch_idx + IDX_W'(1);
        nxt_word = word_q[0];
        for (int i = 0; i < NUM_CH; i++)
            if (nxt_idx == IDX_W'(i))
                nxt_word = word_q[i];
        crc_nxt = crc_upd(crc, out_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_en_q  <= 1'b0;
            crc       <= '0;
            ch_idx    <= '0;
            stall_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            crc_out   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (start) begin
                        crc_en_q  <= crc_en;
                        crc       <= CRC_INIT;
                        ch_idx    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= ch_data[DATA_W-1:0];
                        out_last  <= (NUM_CH == 1) && !crc_en;
                        busy      <= 1'b1;
                        state     <= PUSH;
                    end
                end
                PUSH: begin
                    if (hs) begin
                        stall_cnt <= '0;
                        crc       <= crc_nxt;
                        if (ch_idx == LAST_IDX) begin
                            if (crc_en_q) begin
                                out_data <= crc_nxt;
                                out_last <= 1'b1;
                                state    <= CRC;
                            end else begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                crc_out   <= crc_nxt;
                                state     <= IDLE;
                            end
                        end else begin
                            ch_idx   <= nxt_idx;
                            out_data <= nxt_word;
                            out_last <= (nxt_idx == LAST_IDX) && !crc_en_q;
                        end
                    end else if (tmo) begin
                        stall_cnt <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end else if (stall) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                CRC: begin
                    // crc already holds the channel-only CRC; the CRC beat is not folded in.
                    if (hs) begin
                        stall_cnt <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        crc_out   <= crc;
                        state     <= IDLE;
                    end else if (tmo) begin
                        stall_cnt <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end else if (stall) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
